// File: rtl/fps_pkg.sv
// fps_pkg
//   Shared definitions for the fps display path (fps_counter, fps_bcd_reader).
//   Holds the default counter width, the matching BCD digit count and the
//   converter state encoding.
package fps_pkg;

    // 10 decimal digits cover the full 32-bit range (4294967295).
    localparam int FPS_WIDTH  = 32;
    localparam int FPS_DIGITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } fps_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust
//   Double-dabble correction for one BCD digit: a digit of 5 or more gets 3
//   added so that the following left shift carries correctly into the next
//   decimal digit.
//   Ports:
//     digit_in  - current BCD digit
//     digit_out - corrected digit, ready to be shifted
module bcd_digit_adjust (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/fps_bcd_reader.sv
// fps_bcd_reader
//   Converts the binary fps value into BCD digits for display using a
//   sequential double-dabble (one bit per cycle). A conversion starts only
//   when fps_in changes (or once after reset), so a steady value produces a
//   single result pulse.
//   Ports:
//     clk_in        - clock
//     rst_n_in      - asynchronous active-low reset
//     fps_in        - binary fps value, held between updates
//     bcd_out       - BCD digits, digit 0 (ones) in bits [3:0]
//     ndigits_out   - number of significant digits (1 for value 0)
//     bcd_valid_out - one-cycle pulse when bcd_out/ndigits_out update
//     busy_out      - conversion in progress
module fps_bcd_reader
    import fps_pkg::*;
#(
    parameter int WIDTH  = FPS_WIDTH,
    parameter int DIGITS = FPS_DIGITS
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [WIDTH-1:0]             fps_in,
    output logic [4*DIGITS-1:0]          bcd_out,
    output logic [$clog2(DIGITS+1)-1:0]  ndigits_out,
    output logic                         bcd_valid_out,
    output logic                         busy_out
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int NW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    fps_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  bin_q;
    logic [WIDTH-1:0]  last_q;
    logic [BW-1:0]     bcd_q;
    logic [BW-1:0]     bcd_adj;
    logic              force_q;
    logic              start;
    logic [NW-1:0]     nd;

    // Per-digit add-3 correction applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (bcd_q[4*g +: 4]),
            .digit_out (bcd_adj[4*g +: 4])
        );
    end

    // Significant digit count: position of the top nonzero digit, min 1.
    always_comb begin
        nd = NW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) nd = NW'(i + 1);
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (force_q || (fps_in != last_q)) begin
                    start   = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Datapath. Shift state lives in bcd_q/bin_q only; the visible outputs
    // are loaded once per conversion when leaving DONE.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q         <= '0;
            bin_q         <= '0;
            last_q        <= '0;
            bcd_q         <= '0;
            force_q       <= 1'b1;
            bcd_out       <= '0;
            ndigits_out   <= NW'(1);
            bcd_valid_out <= 1'b0;
        end else begin
            bcd_valid_out <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        bin_q   <= fps_in;
                        last_q  <= fps_in;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        force_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    cnt_q          <= cnt_q + CW'(1);
                end
                ST_DONE: begin
                    bcd_out       <= bcd_q;
                    ndigits_out   <= nd;
                    bcd_valid_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_out = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fps_bcd_reader.sv
// tb_fps_bcd_reader
//   Randomized and directed stimulus against a cycle-count reference model:
//   a change of fps (or reset release) starts a conversion taking WIDTH+1
//   cycles of busy, after which the decimal digits of the sampled value
//   appear with a single valid pulse.
module tb_fps_bcd_reader;
    import fps_pkg::*;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;
    localparam int NW     = $clog2(DIGITS + 1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [WIDTH-1:0]     fps = '0;
    logic [4*DIGITS-1:0]  bcd;
    logic [NW-1:0]        nd;
    logic                 vld;
    logic                 busy;

    fps_bcd_reader #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .fps_in        (fps),
        .bcd_out       (bcd),
        .ndigits_out   (nd),
        .bcd_valid_out (vld),
        .busy_out      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    bit                   m_force;
    longint unsigned      m_last, m_val;
    int                   m_busy;
    logic [4*DIGITS-1:0]  e_bcd;
    int                   e_nd;
    bit                   e_vld;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input longint unsigned v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int ndig(input longint unsigned v);
        int n;
        n = 1;
        while (v >= 10) begin
            n++;
            v = v / 10;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_force = 1'b1;
        m_last  = 0;
        m_val   = 0;
        m_busy  = 0;
        e_bcd   = '0;
        e_nd    = 1;
        e_vld   = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            e_vld = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    e_vld = 1'b1;
                    e_bcd = to_bcd(m_val);
                    e_nd  = ndig(m_val);
                end
            end else if (m_force || (longint'(fps) != m_last)) begin
                m_val   = fps;
                m_last  = fps;
                m_force = 1'b0;
                m_busy  = WIDTH + 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("valid",   vld,  e_vld);
        chk("busy",    busy, m_busy > 0);
        chk("bcd",     bcd,  e_bcd);
        chk("ndigits", nd,   e_nd);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Step until a valid pulse, bounded; returns the number of edges taken.
    task automatic wait_vld(input string tag, input int bound, output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while (!vld && edges < bound);
        if (!vld) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        model_reset();

        // reset state
        repeat (3) step();
        rst_n = 1'b1;

        // forced conversion of 0 after reset release
        wait_vld("rst0", 40, lat);
        chk("rst0_latency", lat, 34);
        chk("rst0_bcd", bcd, 0);
        chk("rst0_nd", nd, 1);
        run(10);

        // 0 -> 100
        fps = 100;
        wait_vld("v100", 40, lat);
        chk("v100_latency", lat, 34);
        chk("v100_bcd", bcd[11:0], 12'h100);
        chk("v100_nd", nd, 3);
        run(10);

        // maximum value
        fps = '1;
        wait_vld("vmax", 40, lat);
        chk("vmax_bcd", bcd, 40'h4294967295);
        chk("vmax_nd", nd, 10);
        run(10);

        // change while busy: 50 then 60 mid-shift
        fps = 50;
        run(6);
        fps = 60;
        run(80);

        // reset at shift cycle 10 aborts, then fresh conversion
        fps = 77;
        run(11);
        pulse_reset();
        run(45);

        // random changes, with repeats and small values
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: fps = $urandom;
                1: fps = $urandom_range(0, 999);
                2: fps = fps;
                default: fps = $urandom_range(0, 99999);
            endcase
            if ($urandom_range(0, 15) == 0) pulse_reset();
            run($urandom_range(1, 45));
        end
        run(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
